// File: rtl/cpu65_pkg.sv
// Shared types and vector constants for the 65xx interrupt sequencer.
package cpu65_pkg;

    typedef enum logic [1:0] {
        SRC_RESET = 2'd0,
        SRC_NMI   = 2'd1,
        SRC_IRQ   = 2'd2,
        SRC_BRK   = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        PUSH_NONE = 2'd0,
        PUSH_PCH  = 2'd1,
        PUSH_PCL  = 2'd2,
        PUSH_P    = 2'd3
    } push_e;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_IDLE = 2'd1,
        ST_SEQ  = 2'd2
    } state_e;

    localparam logic [15:0] VEC_RESET = 16'hFFFC;
    localparam logic [15:0] VEC_NMI   = 16'hFFFA;
    localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

    function automatic logic [15:0] vector_base(input src_e s);
        logic [15:0] v;
        case (s)
            SRC_RESET: v = VEC_RESET;
            SRC_NMI:   v = VEC_NMI;
            SRC_IRQ:   v = VEC_IRQ;
            SRC_BRK:   v = VEC_IRQ;
            default:   v = VEC_IRQ;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// Falling-edge detector for the NMI line; samples every phi2 cycle, independent of rdy.
module nmi_edge_detect (
    input  logic phi2,
    input  logic nmib,
    output logic nmi_edge
);

    logic nmib_prev_r;

    // Previous-cycle sample; tracking through reset keeps a stale edge from appearing afterwards.
    always_ff @(negedge phi2) begin
        nmib_prev_r <= nmib;
    end

    assign nmi_edge = nmib_prev_r & ~nmib;

endmodule

// File: rtl/interrupt_sequencer.sv
// Reset/NMI/IRQ/BRK entry sequencer: stack pushes, vector fetch and flag updates.
module interrupt_sequencer
    import cpu65_pkg::*;
(
    input  logic        phi2,
    input  logic        resb,
    input  logic        rdy,
    input  logic        irqb,
    input  logic        nmib,
    input  logic        i_flag,
    input  logic        sync,
    input  logic        brk_req,
    output logic        int_active,
    output logic [2:0]  step,
    output logic [1:0]  src,
    output logic        force_brk,
    output logic [1:0]  push_sel,
    output logic        rwb,
    output logic        vpb,
    output logic        set_i,
    output logic        clear_d,
    output logic        b_flag,
    output logic [15:0] vector_addr
);

    state_e     state_r, state_s;
    src_e       src_r, src_s;
    logic [2:0] step_r, step_s;
    logic       nmi_pend_r, nmi_pend_s;
    logic       rst_pend_r, rst_pend_s;
    logic       nmi_edge_s;
    logic       irq_s;
    logic       take_s;

    nmi_edge_detect u_nmi_edge (
        .phi2     (phi2),
        .nmib     (nmib),
        .nmi_edge (nmi_edge_s)
    );

    // Sequencer state register with synchronous active-low reset.
    always_ff @(negedge phi2) begin
        if (!resb) begin
            state_r    <= ST_HOLD;
            step_r     <= 3'd0;
            src_r      <= SRC_RESET;
            nmi_pend_r <= 1'b0;
            rst_pend_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            step_r     <= step_s;
            src_r      <= src_s;
            nmi_pend_r <= nmi_pend_s;
            rst_pend_r <= rst_pend_s;
        end
    end

    // Next-state logic: source arbitration, step advance and NMI hijack.
    always_comb begin
        state_s    = state_r;
        step_s     = step_r;
        src_s      = src_r;
        rst_pend_s = rst_pend_r;
        nmi_pend_s = nmi_pend_r | nmi_edge_s;
        irq_s      = ~irqb & ~i_flag;
        take_s     = (state_r == ST_IDLE) && sync && rdy && (rst_pend_r || nmi_pend_r || irq_s);
        case (state_r)
            ST_HOLD: begin
                state_s    = ST_SEQ;
                step_s     = 3'd0;
                src_s      = SRC_RESET;
                rst_pend_s = 1'b0;
            end
            ST_IDLE: begin
                if (take_s) begin
                    state_s = ST_SEQ;
                    step_s  = 3'd0;
                    if (rst_pend_r) begin
                        src_s      = SRC_RESET;
                        rst_pend_s = 1'b0;
                    end else if (nmi_pend_r) begin
                        src_s = SRC_NMI;
                    end else begin
                        src_s = SRC_IRQ;
                    end
                end else if (brk_req && rdy) begin
                    state_s = ST_SEQ;
                    step_s  = 3'd1;
                    src_s   = SRC_BRK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEQ: begin
                // A late NMI may still redirect the vector as long as P has not been pushed yet.
                if (nmi_edge_s && (step_r <= 3'd4) && ((src_r == SRC_IRQ) || (src_r == SRC_BRK))) begin
                    src_s = SRC_NMI;
                end else begin
                    src_s = src_r;
                end
                if (rdy) begin
                    if (step_r == 3'd6) begin
                        state_s = ST_IDLE;
                        step_s  = 3'd0;
                    end else begin
                        step_s = step_r + 3'd1;
                    end
                end else begin
                    step_s = step_r;
                end
                if (rdy && (step_r == 3'd4) && (src_s == SRC_NMI)) begin
                    nmi_pend_s = 1'b0;
                end else begin
                    nmi_pend_s = nmi_pend_r | nmi_edge_s;
                end
            end
            default: begin
                state_s = ST_HOLD;
                step_s  = 3'd0;
            end
        endcase
    end

    // Output decode from the registered step and source.
    always_comb begin
        int_active  = 1'b0;
        step        = step_r;
        src         = src_r;
        force_brk   = take_s;
        push_sel    = PUSH_NONE;
        rwb         = 1'b1;
        vpb         = 1'b1;
        set_i       = 1'b0;
        clear_d     = 1'b0;
        b_flag      = 1'b0;
        vector_addr = 16'hFFFF;
        if (state_r == ST_SEQ) begin
            int_active = 1'b1;
            case (step_r)
                3'd2: begin
                    push_sel = PUSH_PCH;
                    rwb      = (src_r == SRC_RESET);
                end
                3'd3: begin
                    push_sel = PUSH_PCL;
                    rwb      = (src_r == SRC_RESET);
                end
                3'd4: begin
                    push_sel = PUSH_P;
                    rwb      = (src_r == SRC_RESET);
                    b_flag   = (src_r == SRC_BRK);
                end
                3'd5: begin
                    vpb         = 1'b0;
                    vector_addr = vector_base(src_r);
                    set_i       = rdy;
                    clear_d     = rdy;
                end
                3'd6: begin
                    vpb         = 1'b0;
                    vector_addr = vector_base(src_r) + 16'd1;
                end
                default: begin
                    push_sel = PUSH_NONE;
                end
            endcase
        end else begin
            int_active = 1'b0;
        end
    end

endmodule
